// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt/exception controller: Count/Compare timer with prescaler,
// Status/Cause/EPC/BadVAddr/Debug registers, hardware interrupt
// synchronisers and the combinational interrupt request.
module cp0_irq_ctrl #(
    parameter int N_HW_IRQ  = 5,
    parameter int RAM_DEPTH = 14,
    parameter int COUNT_DIV = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [4:0]          IDX,
    input  logic                WE,
    input  logic [31:0]         WD,
    output logic [31:0]         RD,
    input  logic                IEN_WB,
    input  logic [N_HW_IRQ-1:0] HW_IRQ,
    input  logic                E_ENTER,
    input  logic                ERET,
    input  logic [4:0]          CAUSE,
    input  logic                DELAY_SLOT,
    input  logic [31:0]         EPC,
    input  logic [31:0]         BAD_VA,
    output logic                INT_REQ,
    output logic [31:0]         EPC_Q,
    output logic                KERNEL_MODE,
    output logic [31:0]         DEBUG_DATA
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    localparam logic [4:0] IDX_BADVA   = 5'd8;
    localparam logic [4:0] IDX_COUNT   = 5'd9;
    localparam logic [4:0] IDX_COMPARE = 5'd11;
    localparam logic [4:0] IDX_STATUS  = 5'd12;
    localparam logic [4:0] IDX_CAUSE   = 5'd13;
    localparam logic [4:0] IDX_EPC     = 5'd14;
    localparam logic [4:0] IDX_PRID    = 5'd15;
    localparam logic [4:0] IDX_CONFIG  = 5'd16;
    localparam logic [4:0] IDX_DEBUG   = 5'd23;

    logic [N_HW_IRQ-1:0] hw_sync1_q, hw_sync2_q;
    logic [31:0]         count_q, count_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [31:0]         compare_q, compare_d;
    logic [7:0]          im_q, im_d;
    logic                ie_q, ie_d;
    logic                exl_q, exl_d;
    logic [1:0]          sw_ip_q, sw_ip_d;
    logic                timer_q, timer_d;
    logic                bd_q, bd_d;
    logic [4:0]          exc_code_q, exc_code_d;
    logic [31:0]         badva_q, badva_d;
    logic [31:0]         epc_q, epc_d;
    logic [31:0]         debug_q, debug_d;

    logic [4:0] hw_ip;
    logic [7:0] ip;
    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_debug;

    assign wr_count   = WE && (IDX == IDX_COUNT);
    assign wr_compare = WE && (IDX == IDX_COMPARE);
    assign wr_status  = WE && (IDX == IDX_STATUS);
    assign wr_cause   = WE && (IDX == IDX_CAUSE);
    assign wr_epc     = WE && (IDX == IDX_EPC);
    assign wr_debug   = WE && (IDX == IDX_DEBUG);

    // Pending-interrupt vector; unimplemented hardware lines read 0.
    always_comb begin
        hw_ip                 = '0;
        hw_ip[N_HW_IRQ-1:0]   = hw_sync2_q;
        ip                    = {timer_q, hw_ip, sw_ip_q};
    end

    // Next-state for every architectural register.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        count_d    = count_q;
        presc_d    = presc_q;
        compare_d  = compare_q;
        im_d       = im_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        sw_ip_d    = sw_ip_q;
        timer_d    = timer_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        badva_d    = badva_q;
        epc_d      = epc_q;
        debug_d    = debug_q;

        // Count with prescaler; a software load restarts the prescale period.
        if (wr_count) begin
            count_d = WD;
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Timer match sets the pending bit; a Compare write clears it and wins.
        if ((count_q == compare_q) && !wr_count) timer_d = 1'b1;
        if (wr_compare) begin
            compare_d = WD;
            timer_d   = 1'b0;
        end

        if (wr_status) begin
            im_d = WD[15:8];
            ie_d = WD[0];
        end
        if (wr_cause) sw_ip_d = WD[9:8];
        if (wr_debug) debug_d = WD;
        if (wr_epc)   epc_d   = WD;

        // Exception entry overrides both ERET and a software EPC write.
        if (E_ENTER) begin
            exl_d      = 1'b1;
            bd_d       = DELAY_SLOT;
            exc_code_d = CAUSE;
            badva_d    = BAD_VA;
            epc_d      = EPC;
        end else if (ERET) begin
            exl_d = 1'b0;
        end
    end

    // State registers and the two-flop interrupt synchroniser.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RESET) begin
            hw_sync1_q <= '0;
            hw_sync2_q <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            compare_q  <= '0;
            im_q       <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            sw_ip_q    <= '0;
            timer_q    <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            badva_q    <= '0;
            epc_q      <= '0;
            debug_q    <= '0;
        end else begin
            hw_sync1_q <= HW_IRQ;
            hw_sync2_q <= hw_sync1_q;
            count_q    <= count_d;
            presc_q    <= presc_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            sw_ip_q    <= sw_ip_d;
            timer_q    <= timer_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            badva_q    <= badva_d;
            epc_q      <= epc_d;
            debug_q    <= debug_d;
        end
    end

    // Combinational register read mux.
    always_comb begin
        case (IDX)
            IDX_BADVA:   RD = badva_q;
            IDX_COUNT:   RD = count_q;
            IDX_COMPARE: RD = compare_q;
            IDX_STATUS:  RD = {16'b0, im_q, 6'b0, exl_q, ie_q};
            IDX_CAUSE:   RD = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
            IDX_EPC:     RD = epc_q;
            IDX_PRID:    RD = 32'hDEADBEF0 | 32'(N_HW_IRQ);
            IDX_CONFIG:  RD = 32'd1 << (RAM_DEPTH + 2);
            IDX_DEBUG:   RD = debug_q;
            default:     RD = 32'd0;
        endcase
    end

    assign INT_REQ     = (|(ip & im_q)) & ie_q & ~exl_q & IEN_WB;
    assign EPC_Q       = epc_q;
    assign KERNEL_MODE = exl_q;
    assign DEBUG_DATA  = debug_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: register read-back tables plus
// hand-written timer, hardware IRQ, exception, prescaler and reset sequences.
module tb_cp0_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idx;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd, rd4;
    logic        ien_wb;
    logic [2:0]  hw_irq;
    logic [4:0]  hw_irq5;
    logic        e_enter, eret;
    logic [4:0]  cause;
    logic        delay_slot;
    logic [31:0] epc, bad_va;
    logic        int_req, int_req4;
    logic [31:0] epc_q, epc_q4;
    logic        kernel_mode, kernel_mode4;
    logic [31:0] debug_data, debug_data4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cp0_irq_ctrl #(.N_HW_IRQ(3), .RAM_DEPTH(14), .COUNT_DIV(1)) dut (
        .CLK(clk), .RESET(reset), .IDX(idx), .WE(we), .WD(wd), .RD(rd),
        .IEN_WB(ien_wb), .HW_IRQ(hw_irq), .E_ENTER(e_enter), .ERET(eret),
        .CAUSE(cause), .DELAY_SLOT(delay_slot), .EPC(epc), .BAD_VA(bad_va),
        .INT_REQ(int_req), .EPC_Q(epc_q), .KERNEL_MODE(kernel_mode),
        .DEBUG_DATA(debug_data)
    );

    cp0_irq_ctrl #(.N_HW_IRQ(5), .RAM_DEPTH(14), .COUNT_DIV(4)) dut_div4 (
        .CLK(clk), .RESET(reset), .IDX(idx), .WE(we), .WD(wd), .RD(rd4),
        .IEN_WB(ien_wb), .HW_IRQ(hw_irq5), .E_ENTER(e_enter), .ERET(eret),
        .CAUSE(cause), .DELAY_SLOT(delay_slot), .EPC(epc), .BAD_VA(bad_va),
        .INT_REQ(int_req4), .EPC_Q(epc_q4), .KERNEL_MODE(kernel_mode4),
        .DEBUG_DATA(debug_data4)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] wd;
        logic [31:0] exp;
    } wr_vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    wr_vec_t wr_tab[11];
    rd_vec_t rst_tab[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2ns after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] i, input logic [31:0] d);
        idx = i; wd = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] i, input logic [31:0] exp, input string name);
        idx = i;
        #1;
        check(name, rd, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; idx = '0; we = 1'b0; wd = '0; ien_wb = 1'b0;
        hw_irq = '0; hw_irq5 = '0; e_enter = 1'b0; eret = 1'b0;
        cause = '0; delay_slot = 1'b0; epc = '0; bad_va = '0;

        wr_tab[0]  = '{5'd11, 32'hFFFF0000, 32'hFFFF0000};
        wr_tab[1]  = '{5'd12, 32'hFFFFFFFF, 32'h0000FF01};
        wr_tab[2]  = '{5'd13, 32'hFFFFFFFF, 32'h00000300};
        wr_tab[3]  = '{5'd14, 32'h12345678, 32'h12345678};
        wr_tab[4]  = '{5'd23, 32'hCAFEBABE, 32'hCAFEBABE};
        wr_tab[5]  = '{5'd8,  32'h55555555, 32'h00000000};
        wr_tab[6]  = '{5'd15, 32'h00000000, 32'hDEADBEF3};
        wr_tab[7]  = '{5'd16, 32'h00000000, 32'h00010000};
        wr_tab[8]  = '{5'd5,  32'hFFFFFFFF, 32'h00000000};
        wr_tab[9]  = '{5'd31, 32'hFFFFFFFF, 32'h00000000};
        wr_tab[10] = '{5'd9,  32'h00000100, 32'h00000100};

        rst_tab[0] = '{5'd8,  32'h0};
        rst_tab[1] = '{5'd9,  32'h0};
        rst_tab[2] = '{5'd11, 32'h0};
        rst_tab[3] = '{5'd12, 32'h0};
        rst_tab[4] = '{5'd13, 32'h0};
        rst_tab[5] = '{5'd14, 32'h0};
        rst_tab[6] = '{5'd23, 32'h0};
        rst_tab[7] = '{5'd15, 32'hDEADBEF3};
        rst_tab[8] = '{5'd16, 32'h00010000};

        step();
        step();
        reset = 1'b0;

        // Reset state of both instances.
        for (int i = 0; i < 9; i++)
            rd_chk(rst_tab[i].idx, rst_tab[i].exp, $sformatf("reset_rd idx%0d", rst_tab[i].idx));
        check("reset int_req", 32'(int_req), 32'd0);
        check("reset kernel_mode", 32'(kernel_mode), 32'd0);
        check("reset epc_q", epc_q, 32'd0);
        idx = 5'd15; #1;
        check("div4 prid", rd4, 32'hDEADBEF5);

        // Write/read-back table (first row's Compare write also beats the post-reset timer match).
        do_reset();
        for (int i = 0; i < 11; i++) begin
            wr(wr_tab[i].idx, wr_tab[i].wd);
            rd_chk(wr_tab[i].idx, wr_tab[i].exp, $sformatf("wr_rd row%0d idx%0d", i, wr_tab[i].idx));
        end

        // No write-through: old value visible during the write cycle, new value after.
        idx = 5'd23; wd = 32'h00000011; we = 1'b1; #1;
        check("debug no bypass", rd, 32'hCAFEBABE);
        step();
        we = 1'b0;
        rd_chk(5'd23, 32'h00000011, "debug after write");
        check("debug_data port", debug_data, 32'h00000011);

        // Timer: Compare=10, IM7+IE, Count reload to 0.
        do_reset();
        ien_wb = 1'b1;
        wr(5'd11, 32'd10);
        wr(5'd12, 32'h00008001);
        wr(5'd9, 32'd0);
        rd_chk(5'd9, 32'd0, "timer count start");
        repeat (10) step();
        rd_chk(5'd9, 32'd10, "timer count at 10");
        idx = 5'd13; #1;
        check("timer ip7 before", 32'(rd[15]), 32'd0);
        check("timer int before", 32'(int_req), 32'd0);
        step();
        check("timer ip7 set", 32'(rd[15]), 32'd1);
        check("timer int set", 32'(int_req), 32'd1);
        wr(5'd11, 32'h00001000);
        idx = 5'd13; #1;
        check("timer ip7 cleared", 32'(rd[15]), 32'd0);
        check("timer int cleared", 32'(int_req), 32'd0);

        // Hardware IRQ through the 2-flop synchroniser.
        do_reset();
        wr(5'd11, 32'hFFFFFFFF);
        wr(5'd12, 32'h00001001);
        ien_wb = 1'b1;
        hw_irq = 3'b100;
        step();
        idx = 5'd13; #1;
        check("hw ip4 after 1", 32'(rd[12]), 32'd0);
        check("hw int after 1", 32'(int_req), 32'd0);
        step();
        idx = 5'd13; #1;
        check("hw ip4 after 2", 32'(rd[12]), 32'd1);
        check("hw int after 2", 32'(int_req), 32'd1);
        ien_wb = 1'b0; #1;
        check("hw int bubble", 32'(int_req), 32'd0);
        hw_irq = 3'b111;
        step();
        step();
        idx = 5'd13; #1;
        check("hw ip[6:0] n3", 32'(rd[14:8]), 32'h1C);
        hw_irq = 3'b000;

        // Exception entry with simultaneous ERET and EPC write.
        do_reset();
        wr(5'd11, 32'hFFFFFFFF);
        wr(5'd12, 32'h0000FF01);
        ien_wb = 1'b1;
        e_enter = 1'b1; eret = 1'b1; epc = 32'h400; cause = 5'd4;
        delay_slot = 1'b1; bad_va = 32'h0BADBAD0;
        idx = 5'd14; wd = 32'h123; we = 1'b1;
        step();
        e_enter = 1'b0; eret = 1'b0; we = 1'b0; delay_slot = 1'b0;
        check("exc epc_q", epc_q, 32'h400);
        check("exc kernel", 32'(kernel_mode), 32'd1);
        rd_chk(5'd13, 32'h80000010, "exc cause");
        rd_chk(5'd8, 32'h0BADBAD0, "exc badva");
        wr(5'd13, 32'h00000100);
        rd_chk(5'd13, 32'h80000110, "exc cause sw0");
        check("exc int masked", 32'(int_req), 32'd0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        #1;
        check("eret kernel", 32'(kernel_mode), 32'd0);
        check("eret int", 32'(int_req), 32'd1);

        // Prescaler on the COUNT_DIV=4 instance: wrap 4 cycles after the load.
        do_reset();
        wr(5'd9, 32'hFFFFFFFF);
        repeat (3) step();
        idx = 5'd9; #1;
        check("div4 count hold", rd4, 32'hFFFFFFFF);
        step();
        idx = 5'd9; #1;
        check("div4 count wrap", rd4, 32'h00000000);

        // Software interrupt, then reset with writes/exception attempted.
        do_reset();
        wr(5'd11, 32'hFFFFFFFF);
        wr(5'd12, 32'h00000101);
        wr(5'd13, 32'h00000100);
        wr(5'd14, 32'h44);
        wr(5'd23, 32'h55);
        ien_wb = 1'b1;
        #1;
        check("sw int", 32'(int_req), 32'd1);
        reset = 1'b1; we = 1'b1; idx = 5'd23; wd = 32'h77;
        e_enter = 1'b1; epc = 32'h999;
        step();
        reset = 1'b0; we = 1'b0; e_enter = 1'b0;
        for (int i = 0; i < 9; i++)
            rd_chk(rst_tab[i].idx, rst_tab[i].exp, $sformatf("rerst_rd idx%0d", rst_tab[i].idx));
        check("rerst int_req", 32'(int_req), 32'd0);
        check("rerst kernel_mode", 32'(kernel_mode), 32'd0);
        check("rerst epc_q", epc_q, 32'd0);
        check("rerst debug_data", debug_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_irq_ctrl.md
CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have parameter N_HW_IRQ, default 5, meaning the number of hardware interrupt lines (legal range 1..5).
REQ-002 SHALL have parameter RAM_DEPTH, default 14, meaning log2 of the RAM word count, reported in Config.
REQ-003 SHALL have parameter COUNT_DIV, default 1, meaning the number of CLK cycles per Count increment (legal range 1..256).
REQ-004 Ports, in this order:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- IDX  in  5  CP0 register index, for read and write
- WE  in  1  write strobe (MTC0)
- WD  in  32  write data
- RD  out  32  combinational read data for IDX
- IEN_WB  in  1  writeback stage holds a real instruction; 0 at pipeline bubbles
- HW_IRQ  in  N_HW_IRQ  asynchronous level-sensitive interrupt lines
- E_ENTER  in  1  exception entry strobe
- ERET  in  1  exception return strobe
- CAUSE  in  5  exception code
- DELAY_SLOT  in  1  excepting instruction is in a branch delay slot
- EPC  in  32  PC to save on entry
- BAD_VA  in  32  faulting address
- INT_REQ  out  1  interrupt request to the exception unit
- EPC_Q  out  32  current EPC
- KERNEL_MODE  out  1  equals Status.EXL
- DEBUG_DATA  out  32  Debug register contents

Function
REQ-005 SHALL synchronise each HW_IRQ bit through 2 flops; IP[2+i] SHALL be the synchronised HW_IRQ[i]; IP bits above 2+N_HW_IRQ-1 and below 7 SHALL read 0.
REQ-006 SHALL hold IP[1:0] as software-interrupt bits, written from WD[9:8] by a Cause write (IDX=13).
REQ-007 SHALL set IP[7] (timer) in the cycle after Count==Compare while Count is not being written; a Compare write SHALL clear it; on a same-cycle set and clear, the clear SHALL win.
REQ-008 Count (9) SHALL increment by 1 (mod 2^32) when the prescaler reaches COUNT_DIV-1, after which the prescaler SHALL wrap to 0; a Count write SHALL load WD and clear the prescaler.
REQ-009 Status (12) SHALL be {16'b0, IM[7:0], 6'b0, EXL, IE}; a write SHALL update IM and IE from WD[15:8] and WD[0]; EXL SHALL NOT be writable by software.
REQ-010 E_ENTER SHALL set EXL; ERET SHALL clear EXL; when both are asserted, E_ENTER SHALL win.
REQ-011 On E_ENTER, the block SHALL capture BD<=DELAY_SLOT, ExcCode<=CAUSE, BadVAddr<=BAD_VA and EPC<=EPC; in the same cycle, E_ENTER SHALL take priority over a software EPC write.
REQ-012 Cause (13) SHALL read {BD, 15'b0, IP[7:0], 1'b0, ExcCode, 2'b0}.
REQ-013 INT_REQ SHALL be combinational: |(IP & IM) & IE & ~EXL & IEN_WB.
REQ-014 Reads:
- 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 23 Debug
- 15 PRId = 32'hDEADBEF0 | N_HW_IRQ
- 16 Config = 2**(RAM_DEPTH+2)
- all other indices read 0; writes to them are ignored
REQ-015 A register written in cycle t SHALL read the new value in cycle t+1; no write-through bypass.

Reset
REQ-016 RESET SHALL clear the following to 0: Count, prescaler, Compare, IM, IE, EXL, IP[1:0], timer pending, BD, ExcCode, BadVAddr, EPC, Debug, and the synchroniser flops.
REQ-017 During RESET, E_ENTER, ERET and WE SHALL have no effect; after RESET, INT_REQ=0, KERNEL_MODE=0 and EPC_Q=0.

Verification
REQ-018 Timer: COUNT_DIV=1; write Compare=10, Status=0x8001, hold IEN_WB=1 -> Cause.IP[7]=1 one cycle after Count=10 and INT_REQ=1; then write Compare -> IP[7]=0 and INT_REQ=0 on the next cycle.
REQ-019 Hardware IRQ: N_HW_IRQ=3; raise HW_IRQ[2] with IM=0x10 and IE=1 -> Cause.IP[4]=1 after 2 cycles, INT_REQ=1; drop IEN_WB -> INT_REQ=0 in the same cycle.
REQ-020 Exception: E_ENTER with EPC=0x400, CAUSE=4, DELAY_SLOT=1, a same-cycle EPC write of 0x123 and ERET=1 -> EPC_Q=0x400, Cause=0x80000010, KERNEL_MODE=1, INT_REQ masked.
REQ-021 Prescaler: COUNT_DIV=4; write Count=0xFFFFFFFF -> Count reads 0 exactly 4 cycles later (wrap-around).
REQ-022 Software interrupt and reset: write Cause WD=0x100 with IM=0x01, IE=1 -> INT_REQ=1; assert RESET for 1 cycle -> all registers read 0, Config=0x10000 (RAM_DEPTH=14), INT_REQ=0.
